pdec_m: RTL and testbench
=========================

PDEC_M -- requirements
Module: pdec_m

Interface
REQ-001 SHALL have parameter MIN_WIDTH, default 2: shortest accepted pulse, in clk cycles; legal range 1..MAX_WIDTH.
REQ-002 SHALL have parameter MAX_WIDTH, default 16: longest accepted pulse, in clk cycles; must be at least 1.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: number of input synchronizer flops; legal values 0 or 2..4.
REQ-004 SHALL define local width W = $clog2(MAX_WIDTH+1).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port in, input, 1 bit: pulse stream, e.g. the output of a pulse former.
REQ-008 SHALL have port valid, output, 1 bit: one-cycle strobe marking an accepted pulse.
REQ-009 SHALL have port width, output, W bits: measured width of the last terminated pulse.
REQ-010 SHALL have port err_short, output, 1 bit: one-cycle strobe for a pulse narrower than MIN_WIDTH.
REQ-011 SHALL have port err_long, output, 1 bit: one-cycle strobe for a pulse wider than MAX_WIDTH.
REQ-012 SHALL have port busy, output, 1 bit: high while state is HIGH or LONG.

Function
REQ-013 SHALL sample in through SYNC_STAGES flops to form s; with SYNC_STAGES=0, s = in.
REQ-014 SHALL register s into s_prev every cycle.
REQ-015 SHALL implement a three-state FSM with states IDLE, HIGH and LONG, plus a W-bit counter cnt.
REQ-016 In IDLE, on s=1 and s_prev=0, SHALL load cnt=1 and go to HIGH; on s=1 with s_prev=1, SHALL stay in IDLE (no level triggering).
REQ-017 In HIGH, on s=1 with cnt<MAX_WIDTH, SHALL increment cnt and stay in HIGH.
REQ-018 In HIGH, on s=1 with cnt=MAX_WIDTH, SHALL pulse err_long for one cycle and go to LONG; cnt holds and width is not updated.
REQ-019 In HIGH, on s=0, SHALL load width=cnt, pulse valid if cnt>=MIN_WIDTH or err_short otherwise, and go to IDLE.
REQ-020 In LONG, SHALL stay while s=1 and go to IDLE on s=0, with no strobe.
REQ-021 SHALL register all outputs; a strobe is visible in the single cycle after the clk edge that decided it.
REQ-022 The measured width SHALL equal the number of clk edges at which s was sampled high, so a pulse former of width N yields width=N.
REQ-023 Latency from the falling edge of in to valid SHALL be SYNC_STAGES+1 clk edges.
REQ-024 valid, err_short and err_long SHALL be mutually exclusive and never high for two consecutive cycles from the same pulse.
REQ-025 width SHALL hold its value between terminations.
REQ-026 Back-to-back pulses with a single low sample between them SHALL each be decoded; the low sample both terminates the first pulse and arms edge detection for the next.
REQ-027 The counter SHALL never wrap: cnt is capped at MAX_WIDTH.

Reset
REQ-028 While rst=1, SHALL force state=IDLE, cnt=0, width=0, valid=0, err_short=0, err_long=0 and busy=0, and preset all synchronizer flops and s_prev to 1.
REQ-029 Because s_prev resets to 1, an input already high at reset release SHALL NOT be decoded until it has gone low and then high again.
REQ-030 Reset asserted mid-pulse SHALL take effect asynchronously, and SHALL produce no strobe for that pulse afterwards.

Verification (MIN_WIDTH=2, MAX_WIDTH=16, SYNC_STAGES=0 unless stated)
REQ-031 A 4-cycle high pulse SHALL produce valid for exactly one cycle with width=4, and busy high for 4 cycles.
REQ-032 A 1-cycle pulse SHALL produce err_short for one cycle and width=1, with no valid.
REQ-033 A 16-cycle pulse SHALL produce valid with width=16; a 20-cycle pulse SHALL produce err_long at the 17th high sample, then no strobe at its fall, with width unchanged.
REQ-034 The sequence 3 high, 1 low, 3 high, then low SHALL produce two valid strobes, each with width=3.
REQ-035 With in held high through reset release and low after 5 cycles: no strobe; a subsequent 2-cycle pulse SHALL produce valid with width=2.
REQ-036 rst pulsed at the 3rd high cycle of an 8-cycle pulse SHALL clear all outputs immediately, with no strobe afterwards; with SYNC_STAGES=2, a 4-cycle pulse SHALL produce valid 3 edges after in falls.

Source files
------------

// File: rtl/pdec_m.sv
// Pulse-width decoder: measures high pulses on in, strobes valid/err_short/err_long.
// Latency: strobe appears SYNC_STAGES+1 clk edges after the deciding input edge.
// Backpressure: none; strobes are single-cycle and must be captured by the consumer.
module pdec_m #(
   parameter int MIN_WIDTH   = 2,
   parameter int MAX_WIDTH   = 16,
   parameter int SYNC_STAGES = 2,
   localparam int W          = $clog2(MAX_WIDTH + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in,
   output logic         valid,
   output logic [W-1:0] width,
   output logic         err_short,
   output logic         err_long,
   output logic         busy
);

   localparam logic [W-1:0] CNT_MAX = W'(MAX_WIDTH);
   localparam logic [W-1:0] CNT_MIN = W'(MIN_WIDTH);

   typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LONG = 2'd2} state_t;

   state_t       state, state_nxt;
   logic         s, s_prev;
   logic [W-1:0] cnt, cnt_nxt, width_nxt;
   logic         valid_nxt, err_short_nxt, err_long_nxt, busy_nxt;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign s = in;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_q;
         // Synchronizer chain, preset high so a level present at reset release is not seen as an edge
         always_ff @(posedge clk or posedge rst) begin
            if (rst) sync_q <= '1;
            else     sync_q <= (sync_q << 1) | SYNC_STAGES'(in);
         end
         assign s = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   // Previous synchronized sample for rising-edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) s_prev <= 1'b1;
      else     s_prev <= s;
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode: arm on rising edge, escape to LONG once the counter is saturated
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (s && !s_prev)       state_nxt = HIGH;
         HIGH:    if (!s)                 state_nxt = IDLE;
                  else if (cnt == CNT_MAX) state_nxt = LONG;
         LONG:    if (!s)                 state_nxt = IDLE;
         default:                         state_nxt = IDLE;
      endcase
   end

   // Output/datapath decode: counter never wraps, width only updates on a normal termination
   always_comb begin
      cnt_nxt       = cnt;
      width_nxt     = width;
      valid_nxt     = 1'b0;
      err_short_nxt = 1'b0;
      err_long_nxt  = 1'b0;
      case (state)
         IDLE: if (s && !s_prev) cnt_nxt = W'(1);
         HIGH: begin
            if (s) begin
               if (cnt < CNT_MAX) cnt_nxt = cnt + W'(1);
               else               err_long_nxt = 1'b1;
            end else begin
               width_nxt = cnt;
               if (cnt >= CNT_MIN) valid_nxt     = 1'b1;
               else                err_short_nxt = 1'b1;
            end
         end
         default: ;
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   // Registered outputs and counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         width     <= '0;
         valid     <= 1'b0;
         err_short <= 1'b0;
         err_long  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         cnt       <= cnt_nxt;
         width     <= width_nxt;
         valid     <= valid_nxt;
         err_short <= err_short_nxt;
         err_long  <= err_long_nxt;
         busy      <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_pdec_m.sv
// Bench for pdec_m: scoreboard of expected strobes (kind, width, cycle) for SYNC_STAGES 0 and 2.
// Latency: expected strobe cycle is derived from the stimulus edge plus synchronizer depth.
// Backpressure: not applicable; strobes are compared as they occur.
module tb_pdec_m;

   localparam int MAXW = 16;

   typedef struct {
      logic [2:0] kind;   // {valid, err_short, err_long}
      int         wid;
      int         due;
   } exp_t;

   logic       clk, rst, in;
   logic       v1, s1, l1, b1, v2, s2, l2, b2;
   logic [4:0] w1, w2;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   model_w = 0;
   int   busy_cnt = 0;
   exp_t q1[$];
   exp_t q2[$];
   exp_t e1, e2;

   pdec_m #(.MIN_WIDTH(2), .MAX_WIDTH(MAXW), .SYNC_STAGES(0)) dut (
      .clk(clk), .rst(rst), .in(in), .valid(v1), .width(w1),
      .err_short(s1), .err_long(l1), .busy(b1));

   pdec_m #(.MIN_WIDTH(2), .MAX_WIDTH(MAXW), .SYNC_STAGES(2)) dut2 (
      .clk(clk), .rst(rst), .in(in), .valid(v2), .width(w2),
      .err_short(s2), .err_long(l2), .busy(b2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Scoreboard for the unsynchronized instance
   always @(negedge clk) begin
      if (!rst) begin
         if (b1) busy_cnt++;
         if (v1 || s1 || l1) begin
            if (q1.size() == 0) chk("spurious1", 1, 0);
            else begin
               e1 = q1.pop_front();
               chk("kind1", int'({v1, s1, l1}), int'(e1.kind));
               chk("width1", int'(w1), e1.wid);
               chk("lat1", cyc, e1.due);
            end
         end
      end
   end

   // Scoreboard for the two-stage synchronizer instance
   always @(negedge clk) begin
      if (!rst) begin
         if (v2 || s2 || l2) begin
            if (q2.size() == 0) chk("spurious2", 1, 0);
            else begin
               e2 = q2.pop_front();
               chk("kind2", int'({v2, s2, l2}), int'(e2.kind));
               chk("width2", int'(w2), e2.wid);
               chk("lat2", cyc, e2.due + 2);
            end
         end
      end
   end

   task automatic gap(input int n);
      in = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives an n-cycle high pulse starting just after a clock edge and records the expected strobe
   task automatic pulse(input int n);
      exp_t e;
      if (n > MAXW) begin
         e.kind = 3'b001;
         e.wid  = model_w;
         e.due  = cyc + MAXW + 1;
      end else begin
         e.kind = (n >= 2) ? 3'b100 : 3'b010;
         e.wid  = n;
         e.due  = cyc + n + 1;
         model_w = n;
      end
      q1.push_back(e);
      q2.push_back(e);
      in = 1'b1;
      repeat (n) @(posedge clk);
      #1 in = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      in  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", int'(v1), 0);
      chk("rst_width", int'(w1), 0);
      chk("rst_busy", int'(b1), 0);
      chk("rst_width2", int'(w2), 0);
      rst = 1'b0;
      gap(4);

      // Nominal pulse with busy duration
      busy_cnt = 0;
      pulse(4);
      gap(8);
      chk("busy_len", busy_cnt, 4);

      // Short pulse, then boundary and overlong pulses
      pulse(1);
      gap(6);
      pulse(16);
      gap(6);
      pulse(20);
      gap(6);
      chk("hold1", int'(w1), model_w);
      chk("hold2", int'(w2), model_w);

      // Back-to-back with a single low sample
      pulse(3);
      gap(1);
      pulse(3);
      gap(8);

      // Input high through reset release must not be decoded
      in  = 1'b1;
      rst = 1'b1;
      model_w = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      gap(6);
      chk("lvl_hold1", int'(w1), 0);
      chk("lvl_busy1", int'(b1), 0);
      pulse(2);
      gap(8);

      // Reset asserted mid-pulse
      in = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_busy1", int'(b1), 0);
      chk("mid_width1", int'(w1), 0);
      chk("mid_busy2", int'(b2), 0);
      chk("mid_width2", int'(w2), 0);
      model_w = 0;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      gap(8);
      chk("mid_after1", int'(b1), 0);

      // Random mix of widths and gaps
      for (int i = 0; i < 12; i++) begin
         pulse(int'($urandom_range(1, 20)));
         gap(int'($urandom_range(1, 4)));
      end
      gap(10);
      chk("sb1_empty", q1.size(), 0);
      chk("sb2_empty", q2.size(), 0);
      chk("final_hold1", int'(w1), model_w);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
